// File: rtl/hivek_pkg.sv
// Shared hivek definitions: machine widths and
// the fetch controller state encoding.
package hivek_pkg;

   localparam int XLEN        = 64;
   localparam int ILEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } fetch_state_t;

   // Clear the byte offset so every address is word aligned.
   function automatic logic [XLEN-1:0] word_align(
      input logic [XLEN-1:0] addr
   );
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: streams words from a synchronous
// memory, handles stall/branch, and yields memory to a loader.
module fetch_ctrl
   import hivek_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            stall,
   input  logic            tb,
   input  logic [XLEN-1:0] b_addr,
   input  logic            ld_req,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [ILEN-1:0] ld_data,
   output logic            ld_gnt,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_wren,
   output logic [ILEN-1:0] mem_wdata,
   input  logic [ILEN-1:0] mem_rdata,
   output logic [XLEN-1:0] pc_o,
   output logic [ILEN-1:0] instr_o,
   output logic            instr_valid
);

   localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

   fetch_state_t    state;
   fetch_state_t    state_n;
   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] fpc_n;
   logic [XLEN-1:0] pc_n;
   logic            valid_n;
   logic [XLEN-1:0] b_al;
   logic [XLEN-1:0] ld_al;

   assign b_al      = word_align(b_addr);
   assign ld_al     = word_align(ld_addr);
   assign mem_wdata = ld_data;
   assign instr_o   = instr_valid ? mem_rdata : '0;

   // Next-state and memory-port arbitration.
   always_comb begin
      state_n  = state;
      fpc_n    = fpc;
      pc_n     = pc_o;
      valid_n  = instr_valid;
      ld_gnt   = 1'b0;
      mem_wren = 1'b0;
      mem_addr = fpc;
      unique case (state)
         RUN: begin
            // A stalled fetch re-reads pc_o so instr_o stays stable.
            mem_addr = tb ? b_al : (stall ? pc_o : fpc);
            if (ld_req) begin
               state_n = LOAD;
               valid_n = 1'b0;
            end else if (tb) begin
               fpc_n   = b_al + STEP;
               pc_n    = b_al;
               valid_n = 1'b1;
            end else if (!stall) begin
               fpc_n   = fpc + STEP;
               pc_n    = fpc;
               valid_n = 1'b1;
            end
         end
         LOAD: begin
            ld_gnt   = 1'b1;
            mem_addr = ld_al;
            mem_wren = ld_req;
            valid_n  = 1'b0;
            if (!ld_req) begin
               state_n = RUN;
               fpc_n   = RESET_PC;
            end
         end
      endcase
   end

   // State, fetch pointer and output register update.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= RUN;
         fpc         <= RESET_PC;
         pc_o        <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_n;
         fpc         <= fpc_n;
         pc_o        <= pc_n;
         instr_valid <= valid_n;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural
// synchronous instruction memory and a fetch scoreboard.
module tb_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        tb;
   logic [63:0] b_addr;
   logic        ld_req;
   logic [63:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_gnt;
   logic [63:0] mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [63:0] pc_o;
   logic [31:0] instr_o;
   logic        instr_valid;

   logic        fill;
   logic [31:0] mem [0:1023];
   logic [31:0] exp_mem [0:1023];

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   fetch_ctrl #(.RESET_PC(64'h0)) dut (
      .clock(clock),
      .reset(reset),
      .stall(stall),
      .tb(tb),
      .b_addr(b_addr),
      .ld_req(ld_req),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .ld_gnt(ld_gnt),
      .mem_addr(mem_addr),
      .mem_wren(mem_wren),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pc_o(pc_o),
      .instr_o(instr_o),
      .instr_valid(instr_valid)
   );

   always #5 clock = ~clock;

   // Synchronous instruction memory, read-before-write.
   always @(posedge clock) begin
      if (fill) begin
         for (int i = 0; i < 1024; i++)
            mem[i] <= 32'hC0DE_0000 | 32'(i);
      end else if (mem_wren) begin
         mem[mem_addr[11:2]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[11:2]];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] pc);
      exp_t x;
      x.pc    = pc;
      x.instr = exp_mem[pc[11:2]];
      sb.push_back(x);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 1024; i++)
         exp_mem[i] = 32'hC0DE_0000 | 32'(i);
      fill = 1'b1; reset = 1'b1; stall = 1'b0; tb = 1'b0;
      b_addr = '0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
      step();
      step();
      fill = 1'b0;
      checks++;
      if (pc_o !== 64'h0 || instr_valid !== 1'b0 ||
          ld_gnt !== 1'b0 || mem_wren !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: pc=%h v=%b gnt=%b wren=%b want 0/0/0/0",
                  pc_o, instr_valid, ld_gnt, mem_wren);
      end
      checks++;
      if (instr_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_instr: got %h want 0", instr_o);
      end
      reset = 1'b0;
      checks++;
      if (mem_addr !== 64'h0) begin
         failures++;
         $display("FAIL reset_addr: got %h want 0", mem_addr);
      end
   endtask

   task automatic test_run();
      for (int k = 0; k < 3; k++) begin
         push_exp(64'(4 * k));
         step();
         e = sb.pop_front();
         checks++;
         if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL run_seq: pc=%h instr=%h v=%b want pc=%h instr=%h v=1",
                     pc_o, instr_o, instr_valid, e.pc, e.instr);
         end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_exp(64'h8);
         step();
         e = sb.pop_front();
         checks++;
         if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: pc=%h instr=%h v=%b want pc=%h instr=%h",
                     pc_o, instr_o, instr_valid, e.pc, e.instr);
         end
      end
      stall = 1'b0;
      push_exp(64'hC);
      step();
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || instr_o !== e.instr) begin
         failures++;
         $display("FAIL stall_resume: pc=%h instr=%h want pc=%h instr=%h",
                  pc_o, instr_o, e.pc, e.instr);
      end
   endtask

   task automatic test_branch();
      stall = 1'b1; tb = 1'b1; b_addr = 64'h103;
      #1;
      checks++;
      if (mem_addr !== 64'h100 || instr_valid !== 1'b1 ||
          instr_o !== exp_mem[3]) begin
         failures++;
         $display("FAIL branch_slot: addr=%h v=%b instr=%h want 100/1/%h",
                  mem_addr, instr_valid, instr_o, exp_mem[3]);
      end
      push_exp(64'h100);
      step();
      tb = 1'b0; stall = 1'b0;
      push_exp(64'h104);
      for (int k = 0; k < 2; k++) begin
         e = sb.pop_front();
         checks++;
         if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL branch_tgt: pc=%h instr=%h want pc=%h instr=%h",
                     pc_o, instr_o, e.pc, e.instr);
         end
         if (k == 0) step();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] tgt [3];
      tgt[0] = 64'h40; tgt[1] = 64'h80; tgt[2] = 64'h84;
      for (int k = 0; k < 3; k++) begin
         tb     = (k < 2);
         b_addr = tgt[k];
         push_exp(tgt[k]);
         step();
         e = sb.pop_front();
         checks++;
         if (pc_o !== e.pc || instr_o !== e.instr) begin
            failures++;
            $display("FAIL b2b_branch: pc=%h instr=%h want pc=%h instr=%h",
                     pc_o, instr_o, e.pc, e.instr);
         end
      end
      tb = 1'b0;
   endtask

   task automatic test_load();
      ld_req = 1'b1; ld_addr = 64'h0; ld_data = 32'h11;
      #1;
      checks++;
      if (ld_gnt !== 1'b0 || mem_wren !== 1'b0) begin
         failures++;
         $display("FAIL load_req_run: gnt=%b wren=%b want 0/0",
                  ld_gnt, mem_wren);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         ld_addr = 64'(4 * i + i);
         ld_data = 32'h11 * 32'(i + 1);
         exp_mem[i] = ld_data;
         #1;
         checks++;
         if (ld_gnt !== 1'b1 || mem_wren !== 1'b1 ||
             mem_addr !== 64'(4 * i) || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_write: gnt=%b wren=%b addr=%h v=%b want 1/1/%h/0",
                     ld_gnt, mem_wren, mem_addr, instr_valid, 64'(4 * i));
         end
         step();
      end
      ld_req = 1'b0;
      #1;
      checks++;
      if (ld_gnt !== 1'b1 || mem_wren !== 1'b0) begin
         failures++;
         $display("FAIL load_end: gnt=%b wren=%b want 1/0", ld_gnt, mem_wren);
      end
      step();
      checks++;
      if (ld_gnt !== 1'b0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL load_exit: gnt=%b v=%b want 0/0", ld_gnt, instr_valid);
      end
      push_exp(64'h0);
      push_exp(64'h4);
      for (int k = 0; k < 2; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_restart: pc=%h instr=%h want pc=%h instr=%h",
                     pc_o, instr_o, e.pc, e.instr);
         end
      end
   endtask

   task automatic test_ld_tb();
      ld_req = 1'b1; tb = 1'b1; b_addr = 64'h200; ld_addr = 64'h300;
      step();
      tb = 1'b0;
      checks++;
      if (ld_gnt !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 64'h300) begin
         failures++;
         $display("FAIL ldtb_enter: gnt=%b v=%b addr=%h want 1/0/300",
                  ld_gnt, instr_valid, mem_addr);
      end
      exp_mem[192] = 32'h11 * 32'd1;
      ld_data = 32'h11;
      ld_req = 1'b0;
      step();
      push_exp(64'h0);
      step();
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL ldtb_dropped: pc=%h instr=%h want pc=%h instr=%h",
                  pc_o, instr_o, e.pc, e.instr);
      end
   endtask

   task automatic test_wrap();
      tb = 1'b1; b_addr = 64'hFFFF_FFFF_FFFF_FFF8;
      push_exp(64'hFFFF_FFFF_FFFF_FFF8);
      push_exp(64'hFFFF_FFFF_FFFF_FFFC);
      push_exp(64'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         tb = 1'b0;
         e = sb.pop_front();
         checks++;
         if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap: pc=%h instr=%h want pc=%h instr=%h",
                     pc_o, instr_o, e.pc, e.instr);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      ld_req = 1'b1; ld_addr = 64'h20;
      step();
      checks++;
      if (ld_gnt !== 1'b1) begin
         failures++;
         $display("FAIL rml_enter: gnt=%b want 1", ld_gnt);
      end
      reset = 1'b1;
      step();
      checks++;
      if (ld_gnt !== 1'b0 || mem_wren !== 1'b0 ||
          instr_valid !== 1'b0 || pc_o !== 64'h0) begin
         failures++;
         $display("FAIL rml_reset: gnt=%b wren=%b v=%b pc=%h want 0/0/0/0",
                  ld_gnt, mem_wren, instr_valid, pc_o);
      end
      reset = 1'b0; ld_req = 1'b0;
      push_exp(64'h0);
      step();
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || instr_o !== e.instr || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL rml_restart: pc=%h instr=%h want pc=%h instr=%h",
                  pc_o, instr_o, e.pc, e.instr);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_stall();
      test_branch();
      test_back_to_back();
      test_load();
      test_ld_tb();
      test_wrap();
      test_reset_mid_load();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset or after a program load.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, high when the consumer cannot accept instr_o this cycle.
REQ-005 SHALL have port tb, input, 1, high when a branch is taken to b_addr.
REQ-006 SHALL have port b_addr, input, 64, the branch target byte address.
REQ-007 SHALL have port ld_req, input, 1, high when the program loader requests instruction memory.
REQ-008 SHALL have port ld_addr, input, 64, the loader write byte address.
REQ-009 SHALL have port ld_data, input, 32, the loader write word.
REQ-010 SHALL have port ld_gnt, output, 1, high when the loader owns memory.
REQ-011 SHALL have port mem_addr, output, 64, the instruction memory byte address.
REQ-012 SHALL have port mem_wren, output, 1, the instruction memory write enable.
REQ-013 SHALL have port mem_wdata, output, 32, the instruction memory write data, equal to ld_data.
REQ-014 SHALL have port mem_rdata, input, 32, the synchronous read data for the address presented in the previous cycle.
REQ-015 SHALL have port pc_o, output, 64, the address of the instruction on instr_o.
REQ-016 SHALL have port instr_o, output, 32, the fetched instruction: mem_rdata when instr_valid=1, else 0.
REQ-017 SHALL have port instr_valid, output, 1, high when instr_o and pc_o are valid.

Function
REQ-018 SHALL implement two states: RUN, where fetch owns memory, and LOAD, where the loader owns memory.
REQ-019 SHALL hold a 64-bit fetch pointer fpc; all addresses are word-aligned, with bits [1:0] of b_addr and ld_addr forced to 0.
REQ-020 SHALL, in RUN, drive mem_addr = tb ? b_addr : (stall ? pc_o : fpc); mem_wren=0; ld_gnt=0.
REQ-021 SHALL, in RUN with ld_req=0, tb=0, stall=0, update fpc<=fpc+4, pc_o<=fpc and instr_valid<=1, giving one-cycle fetch latency.
REQ-022 SHALL, in RUN with stall=1 and tb=0, hold fpc, pc_o and instr_valid; re-reading pc_o keeps instr_o stable.
REQ-023 SHALL give tb priority over stall: fpc<=b_addr+4, pc_o<=b_addr, instr_valid<=1, so the target is on instr_o in the next cycle with no bubble.
REQ-024 SHALL leave the instruction on instr_o during the tb cycle uncancelled (delay-slot semantics).
REQ-025 SHALL compute fpc+4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-026 SHALL, on ld_req=1 in RUN, transition to LOAD with instr_valid<=0 and fpc held; ld_req wins over simultaneous tb/stall, and that branch is dropped.
REQ-027 SHALL, in LOAD, drive ld_gnt=1, mem_addr=ld_addr, mem_wren=ld_req and instr_valid=0, ignoring tb and stall.
REQ-028 SHALL, when ld_req=0 in LOAD, return to RUN with fpc<=RESET_PC and instr_valid<=0; the first valid instruction appears two cycles after ld_req falls.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, force state=RUN, fpc=RESET_PC, pc_o=0, instr_valid=0, overriding all other inputs, including mid-LOAD.
REQ-030 SHALL, with state=RUN, drive ld_gnt=0 and mem_wren=0 in the cycle after reset.

Structure
REQ-031 SHALL take XLEN=64, ILEN=32, INSTR_BYTES=4 and the state enumeration {RUN, LOAD} from the shared package hivek_pkg.
REQ-032 SHALL contain no sub-module: instruction storage is external and the adder and state register are inline.

Verification
REQ-033 SHALL verify reset release with RESET_PC=0: instr_valid=1 with pc_o=0, 4, 8 in successive cycles and instr_o equal to the stored words.
REQ-034 SHALL verify stall for 3 cycles at pc_o=8: pc_o=8 and instr_o are unchanged for 3 cycles, then pc_o=12 follows.
REQ-035 SHALL verify tb=1, b_addr=64'h103 while stall=1: next cycle pc_o=64'h100, then 64'h104.
REQ-036 SHALL verify ld_req for 4 cycles writing 0x11..0x44 to 0..12: ld_gnt=1 for 4 cycles with mem_wren pulses, then fetch restarts at RESET_PC and returns 0x11 first.
REQ-037 SHALL verify simultaneous ld_req and tb: the branch is ignored and the state enters LOAD.
REQ-038 SHALL verify reset mid-LOAD and fpc wrap: both ld_gnt=0 the cycle after reset and pc_o=..FFFC followed by pc_o=0 are observed.
